tdes_block_host: RTL and testbench

- Host-side responder and sequencer for the 3DES engine (`main`).
- Holds the three 64-bit keys and a buffer of plaintext/ciphertext blocks, and serves the engine's key and data fetches.
- Captures each result when the engine pulses `we`, then re-arms the engine for the next block.
- Is the other end of the engine's memory interface: the engine initiates fetches and stores; this block responds to them and batches a run of blocks for a host/CPU port.

---
 rtl/tdes_block_host_if.sv | 44 ++++
 rtl/tdes_block_host.sv | 152 +++++++++++++++
 tb/tb_tdes_block_host.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/tdes_block_host_if.sv
// Host port and engine memory port of the 3DES block host, bundled as one interface.
// slave is the block-host view; master is the host/engine side driving it.
interface tdes_block_host_if #(
  parameter int AW = 4
);
  logic          host_wr;
  logic          host_rd;
  logic          host_sel;
  logic [AW-1:0] host_addr;
  logic [63:0]   host_wdata;
  logic          host_go;
  logic          host_decrypt;
  logic [AW:0]   host_count;
  logic [63:0]   host_rdata;
  logic          busy;
  logic          batch_done;
  logic          error;

  logic          eng_reset_n;
  logic          start;
  logic          decrypt;
  logic [7:0]    key_addr;
  logic [63:0]   key;
  logic [8:0]    data_addr;
  logic [63:0]   dataIn;
  logic [63:0]   dataOut;
  logic          we;
  logic [8:0]    encryp_data_addr;
  logic [2:0]    done;

  modport slave (
    input  host_wr, host_rd, host_sel, host_addr, host_wdata, host_go, host_decrypt, host_count,
    output host_rdata, busy, batch_done, error,
    output eng_reset_n, start, decrypt, key, dataIn, encryp_data_addr,
    input  key_addr, data_addr, dataOut, we, done
  );

  modport master (
    output host_wr, host_rd, host_sel, host_addr, host_wdata, host_go, host_decrypt, host_count,
    input  host_rdata, busy, batch_done, error,
    input  eng_reset_n, start, decrypt, key, dataIn, encryp_data_addr,
    output key_addr, data_addr, dataOut, we, done
  );
endinterface

// File: rtl/tdes_block_host.sv
// Host-side key/data store and block sequencer for the 3DES engine: serves engine fetches,
// captures each store on we, and resets/re-arms the engine once per block of a batch.
module tdes_block_host #(
  parameter int DEPTH   = 16,
  parameter int AW      = 4,
  parameter int TIMEOUT = 1023
) (
  input  logic              clk,
  input  logic              reset,
  tdes_block_host_if.slave  bus
);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_ERST = 3'd1;
  localparam logic [2:0] S_ARM  = 3'd2;
  localparam logic [2:0] S_RUN  = 3'd3;
  localparam logic [2:0] S_NEXT = 3'd4;
  localparam logic [2:0] S_FIN  = 3'd5;

  logic [2:0]    state_q, state_d;
  logic [AW-1:0] cur_idx_q, cur_idx_d;
  logic [AW:0]   count_q, count_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          erst_cnt_q, erst_cnt_d;
  logic          decrypt_q, decrypt_d;
  logic          error_q, error_d;
  logic [63:0]   host_rdata_q;

  logic [63:0] key_mem    [4];
  logic [63:0] data_mem   [DEPTH];
  logic [63:0] result_mem [DEPTH];

  logic          busy;
  logic          count_ok;
  logic          last_blk;
  logic          store_hit;
  logic          stray_we;
  logic          addr_bad;
  logic [8:0]    cur_addr;
  logic [AW-1:0] store_idx;
  logic          unused_sig;

  assign busy      = (state_q != S_IDLE);
  assign cur_addr  = {{(9-AW){1'b0}}, cur_idx_q};
  assign store_idx = bus.data_addr[AW-1:0];
  assign store_hit = (state_q == S_RUN) && bus.we;
  assign stray_we  = (state_q != S_RUN) && bus.we;
  assign addr_bad  = (bus.data_addr != cur_addr);
  assign count_ok  = (bus.host_count != '0) && (bus.host_count <= (AW+1)'(DEPTH));
  assign last_blk  = (({1'b0, cur_idx_q} + (AW+1)'(1)) == count_q);
  assign unused_sig = ^{bus.done, bus.key_addr[7:2]};

  always_comb begin
    state_d    = state_q;
    cur_idx_d  = cur_idx_q;
    count_d    = count_q;
    timer_d    = timer_q;
    erst_cnt_d = erst_cnt_q;
    decrypt_d  = decrypt_q;
    error_d    = error_q;
    case (state_q)
      S_IDLE: begin
        if (bus.host_go) begin
          if (count_ok) begin
            count_d    = bus.host_count;
            decrypt_d  = bus.host_decrypt;
            cur_idx_d  = '0;
            erst_cnt_d = 1'b0;
            error_d    = 1'b0;
            state_d    = S_ERST;
          end else begin
            error_d = 1'b1;
          end
        end
      end
      S_ERST: begin
        erst_cnt_d = ~erst_cnt_q;
        timer_d    = '0;
        if (erst_cnt_q) state_d = S_ARM;
      end
      S_ARM: begin
        timer_d = timer_q + TW'(1);
        state_d = S_RUN;
      end
      S_RUN: begin
        timer_d = timer_q + TW'(1);
        if (bus.we) begin
          state_d = S_NEXT;
        end else if (timer_q == TW'(TIMEOUT - 1)) begin
          error_d = 1'b1;
          state_d = S_FIN;
        end
      end
      S_NEXT: begin
        if (last_blk) begin
          state_d = S_FIN;
        end else begin
          cur_idx_d  = cur_idx_q + AW'(1);
          erst_cnt_d = 1'b0;
          state_d    = S_ERST;
        end
      end
      S_FIN:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Misdirected stores still land in result_mem; only the flag records them.
    if (stray_we || (store_hit && addr_bad)) error_d = 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cur_idx_q    <= '0;
      count_q      <= '0;
      timer_q      <= '0;
      erst_cnt_q   <= 1'b0;
      decrypt_q    <= 1'b0;
      error_q      <= 1'b0;
      host_rdata_q <= '0;
    end else begin
      state_q    <= state_d;
      cur_idx_q  <= cur_idx_d;
      count_q    <= count_d;
      timer_q    <= timer_d;
      erst_cnt_q <= erst_cnt_d;
      decrypt_q  <= decrypt_d;
      error_q    <= error_d;
      if (bus.host_rd) host_rdata_q <= result_mem[bus.host_addr];
    end
  end

  always_ff @(posedge clk) begin
    if (!busy && bus.host_wr) begin
      if (!bus.host_sel && bus.host_addr[1:0] != 2'd3) key_mem[bus.host_addr[1:0]] <= bus.host_wdata;
      if (bus.host_sel) data_mem[bus.host_addr] <= bus.host_wdata;
    end
    if (store_hit) result_mem[store_idx] <= bus.dataOut;
  end

  // start stays up through the first RUN cycle so the engine sees it after leaving reset.
  assign bus.eng_reset_n      = (state_q == S_ARM) || (state_q == S_RUN) || (state_q == S_NEXT);
  assign bus.start            = (state_q == S_ARM) || ((state_q == S_RUN) && (timer_q == TW'(1)));
  assign bus.decrypt          = decrypt_q;
  assign bus.busy             = busy;
  assign bus.batch_done       = (state_q == S_FIN);
  assign bus.error            = error_q;
  assign bus.host_rdata       = host_rdata_q;
  assign bus.key              = (bus.key_addr[1:0] == 2'd3) ? 64'd0 : key_mem[bus.key_addr[1:0]];
  assign bus.dataIn           = data_mem[cur_idx_q];
  assign bus.encryp_data_addr = cur_addr;
endmodule

// File: tb/tb_tdes_block_host.sv
// Bench for tdes_block_host: random batches against an invertible engine stand-in, checked
// against a per-block reference model, plus timeout, bad-store, illegal-access and reset cases.
module tb_tdes_block_host;
  localparam int DEPTH = 16;
  localparam int AW    = 4;
  localparam int TMO   = 20;

  logic clk, reset;
  tdes_block_host_if #(.AW(AW)) bus ();

  tdes_block_host #(.DEPTH(DEPTH), .AW(AW), .TIMEOUT(TMO)) dut (
    .clk(clk), .reset(reset), .bus(bus)
  );

  int n_checks = 0, n_errors = 0;
  logic [63:0] key_m [3];
  logic [63:0] data_m [DEPTH];
  logic [63:0] got_res [DEPTH];

  logic stub_we = 0, inj_we = 0, stub_mute = 0, stub_bad = 0, key_probe = 0;
  logic [7:0] stub_key_addr = 0;
  int wait_n = -1;
  bit parked = 0;
  int rises = 0, lowbad = 0, lowrun = 0, done_cnt = 0;

  assign bus.we       = stub_we | inj_we;
  assign bus.key_addr = key_probe ? 8'd3 : stub_key_addr;

  initial begin clk = 0; forever #5 clk = ~clk; end

  initial begin
    #2000000;
    $display("FAIL watchdog: got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference block transform: any bijection works; the host only routes blocks.
  function automatic logic [63:0] xform(input logic [63:0] x, input logic [63:0] k1,
                                        input logic [63:0] k2, input logic [63:0] k3, input logic dec);
    logic [63:0] t;
    if (!dec) begin
      t = x ^ k1;
      t = {t[50:0], t[63:51]};
      return (t + k2) ^ k3;
    end
    t = (x ^ k3) - k2;
    t = {t[12:0], t[63:13]};
    return t ^ k1;
  endfunction

  function automatic logic [63:0] model(input int i, input logic dec);
    return xform(data_m[i], key_m[0], key_m[1], key_m[2], dec);
  endfunction

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic host_write(input bit sel, input int addr, input logic [63:0] d);
    bus.host_wr = 1; bus.host_sel = sel; bus.host_addr = AW'(addr); bus.host_wdata = d;
    tick();
    bus.host_wr = 0;
  endtask

  task automatic host_read(input int addr, output logic [63:0] d);
    bus.host_rd = 1; bus.host_addr = AW'(addr);
    tick();
    bus.host_rd = 0;
    d = bus.host_rdata;
  endtask

  task automatic start_batch(input bit dec, input int n);
    rises = 0; lowbad = 0; done_cnt = 0;
    bus.host_decrypt = dec; bus.host_count = (AW+1)'(n); bus.host_go = 1;
    tick();
    bus.host_go = 0;
  endtask

  task automatic wait_batch();
    bit seen = 0;
    for (int c = 0; c < 3000; c++) begin
      if (bus.batch_done) begin seen = 1; break; end
      tick();
    end
    if (!seen) chk("batch_done_wait", 64'd0, 64'd1);
    tick();
  endtask

  task automatic run_and_check(input bit dec, input int n);
    start_batch(dec, n);
    wait_batch();
    chk("done_pulses", 64'(done_cnt), 64'd1);
    chk("erst_entries", 64'(rises), 64'(n));
    chk("erst_len_bad", 64'(lowbad), 64'd0);
    chk("batch_error", 64'(bus.error), 64'd0);
    chk("batch_mode", 64'(bus.decrypt), 64'(dec));
    for (int i = 0; i < n; i++) begin
      host_read(i, got_res[i]);
      chk($sformatf("result[%0d]", i), got_res[i], model(i, dec));
    end
  endtask

  task automatic load_keys();
    for (int i = 0; i < 3; i++) begin
      key_m[i] = {$urandom, $urandom};
      host_write(0, i, key_m[i]);
    end
  endtask

  // Engine stand-in: after start, waits 1..15 cycles, fetches keys and data, stores once, parks.
  initial begin : engine_stub
    logic [63:0] k1, k2, k3;
    bus.data_addr = 0; bus.dataOut = 0; bus.done = 3'b101;
    forever begin
      @(posedge clk); #1;
      stub_we = 0;
      if (reset || !bus.eng_reset_n) begin
        wait_n = -1; parked = 0;
      end else if (!parked && wait_n < 0) begin
        if (bus.start) wait_n = stub_mute ? 1000000 : int'($urandom_range(1, 15));
      end else if (wait_n > 0) begin
        wait_n--;
        if (wait_n == 0) begin
          stub_key_addr = {6'($urandom), 2'd0}; #1 k1 = bus.key;
          stub_key_addr = {6'($urandom), 2'd1}; #1 k2 = bus.key;
          stub_key_addr = {6'($urandom), 2'd2}; #1 k3 = bus.key;
          bus.dataOut   = xform(bus.dataIn, k1, k2, k3, bus.decrypt);
          bus.data_addr = stub_bad ? 9'd5 : bus.encryp_data_addr;
          stub_we = 1; parked = 1; wait_n = -1;
        end
      end
    end
  end

  initial begin : monitor
    forever begin
      @(posedge clk); #1;
      if (bus.batch_done) done_cnt++;
      if (!bus.busy) lowrun = 0;
      else if (!bus.eng_reset_n) lowrun++;
      else if (lowrun != 0) begin
        rises++;
        if (lowrun != 2) lowbad++;
        lowrun = 0;
      end
    end
  end

  initial begin : main
    logic [63:0] plain [4];
    logic [63:0] rd;
    int k, g;
    reset = 1;
    bus.host_wr = 0; bus.host_rd = 0; bus.host_sel = 0; bus.host_addr = 0; bus.host_wdata = 0;
    bus.host_go = 0; bus.host_decrypt = 0; bus.host_count = 0;
    repeat (3) tick();
    chk("rst_busy", 64'(bus.busy), 64'd0);
    chk("rst_batch_done", 64'(bus.batch_done), 64'd0);
    chk("rst_error", 64'(bus.error), 64'd0);
    chk("rst_eng_reset_n", 64'(bus.eng_reset_n), 64'd0);
    chk("rst_start", 64'(bus.start), 64'd0);
    chk("rst_decrypt", 64'(bus.decrypt), 64'd0);
    chk("rst_rdata", bus.host_rdata, 64'd0);
    reset = 0;
    tick();

    load_keys();
    for (int i = 0; i < DEPTH; i++) begin
      data_m[i] = {$urandom, $urandom};
      host_write(1, i, data_m[i]);
    end
    run_and_check(0, 1);
    for (int it = 0; it < 3; it++)
      run_and_check(1'($urandom), (it == 0) ? DEPTH : int'($urandom_range(2, DEPTH - 1)));

    // Round trip with fresh, distinct keys.
    load_keys();
    for (int i = 0; i < 4; i++) plain[i] = data_m[i];
    run_and_check(0, 4);
    for (int i = 0; i < 4; i++) begin
      data_m[i] = got_res[i];
      host_write(1, i, data_m[i]);
    end
    run_and_check(1, 4);
    for (int i = 0; i < 4; i++) chk($sformatf("roundtrip[%0d]", i), got_res[i], plain[i]);

    // Engine that never stores: FIN exactly TMO cycles after ARM.
    stub_mute = 1;
    start_batch(0, 2);
    g = 0;
    while (!bus.eng_reset_n && g < 50) begin tick(); g++; end
    k = 0;
    while (!bus.batch_done && k < 200) begin tick(); k++; end
    chk("timeout_cycles", 64'(k), 64'(TMO));
    chk("timeout_error", 64'(bus.error), 64'd1);
    tick();
    chk("timeout_busy_after", 64'(bus.busy), 64'd0);
    chk("timeout_one_block", 64'(rises), 64'd1);
    stub_mute = 0;
    run_and_check(0, 2);

    // Store to the wrong index still writes, and flags error.
    stub_bad = 1;
    start_batch(0, 1);
    wait_batch();
    stub_bad = 0;
    chk("badaddr_error", 64'(bus.error), 64'd1);
    host_read(5, rd);
    chk("badaddr_result5", rd, model(0, 0));

    // Illegal go counts.
    start_batch(0, 0);
    chk("go_cnt0_busy", 64'(bus.busy), 64'd0);
    chk("go_cnt0_error", 64'(bus.error), 64'd1);
    run_and_check(0, 1);
    start_batch(0, DEPTH + 1);
    chk("go_cnt17_busy", 64'(bus.busy), 64'd0);
    chk("go_cnt17_error", 64'(bus.error), 64'd1);

    // Writes and go while busy are ignored.
    start_batch(0, 2);
    host_write(1, 0, ~data_m[0]);
    bus.host_go = 1; bus.host_count = (AW+1)'(1);
    tick();
    bus.host_go = 0;
    wait_batch();
    chk("busy_go_blocks", 64'(rises), 64'd2);
    chk("busy_wr_error", 64'(bus.error), 64'd0);
    host_read(0, rd);
    chk("busy_wr_ignored", rd, model(0, 0));

    // Key index 3 reads as zero and cannot be written.
    host_write(0, 3, {$urandom, $urandom} | 64'd1);
    key_probe = 1; #1;
    chk("key3_zero", bus.key, 64'd0);
    key_probe = 0;

    // Store strobe outside RUN.
    inj_we = 1; tick(); inj_we = 0; tick();
    chk("stray_we_error", 64'(bus.error), 64'd1);

    // Async reset during block 2 of 4, then restart.
    start_batch(0, 4);
    g = 0;
    while (!(bus.encryp_data_addr == 9'd1 && bus.eng_reset_n) && g < 500) begin tick(); g++; end
    chk("reached_block2", 64'(bus.encryp_data_addr), 64'd1);
    #2 reset = 1;
    #1;
    chk("arst_busy", 64'(bus.busy), 64'd0);
    chk("arst_eng_reset_n", 64'(bus.eng_reset_n), 64'd0);
    chk("arst_start", 64'(bus.start), 64'd0);
    chk("arst_error", 64'(bus.error), 64'd0);
    tick();
    reset = 0;
    tick();
    start_batch(1, 1);
    chk("restart_idx", 64'(bus.encryp_data_addr), 64'd0);
    chk("restart_busy", 64'(bus.busy), 64'd1);
    wait_batch();
    host_read(0, rd);
    chk("restart_result0", rd, model(0, 1));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
